// File: rtl/branch_predict_unit_pkg.sv
// bp_pkg: shared mode/counter constants and the BTB entry layout for branch_predict_unit
package bp_pkg;
  localparam int BP_STATIC  = 0;
  localparam int BP_BIMODAL = 1;
  localparam int BP_GSHARE  = 2;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;
  localparam int TAG_MAX = 28;
  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [29:0]        target;
  } btb_entry_t;
endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// sat_counter2: 2-bit saturating counter next state; set wins over inc/dec
module sat_counter2 (
  input  logic [1:0] cnt,
  input  logic       inc,
  input  logic       dec,
  input  logic       set,
  input  logic [1:0] set_val,
  output logic [1:0] nxt
);
  always_comb nxt = set ? set_val : (inc && cnt != 2'd3) ? cnt + 2'd1 : (dec && cnt != 2'd0) ? cnt - 2'd1 : cnt;
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BTB + 2-bit PHT predictor (static/bimodal/gshare) trained from ID with perf counters
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int TAG_W   = 10,
  parameter  int MODE    = 1,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [IDX_W-1:0] pred_pht_idx,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic             id_flush,
  input  logic [31:0]      id_pc,
  input  logic             id_is_cond,
  input  logic             id_taken,
  input  logic [31:0]      id_target,
  input  logic             id_pred_taken,
  input  logic [31:0]      id_pred_target,
  input  logic [IDX_W-1:0] id_pht_idx,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      br_count,
  output logic [31:0]      mispred_count
);
  btb_entry_t       btb_q [ENTRIES];
  btb_entry_t       btb_d [ENTRIES];
  logic [1:0]       pht_q [ENTRIES];
  logic [1:0]       pht_d [ENTRIES];
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic [31:0]      br_count_q, br_count_d, mispred_count_q, mispred_count_d;
  logic [IDX_W-1:0] if_idx, id_idx;
  logic [TAG_W-1:0] if_tag, id_tag;
  logic             btb_hit, id_hit, upd, btb_we, pht_we;
  logic [1:0]       pht_nxt;
  logic             unused_pc;
  assign unused_pc = ^if_pc;
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign id_tag = id_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign btb_hit = btb_q[if_idx].valid && btb_q[if_idx].tag == TAG_MAX'(if_tag);
  assign id_hit = btb_q[id_idx].valid && btb_q[id_idx].tag == TAG_MAX'(id_tag);
  assign pred_pht_idx = (MODE == BP_GSHARE) ? if_idx ^ ghr_q : if_idx;
  // tables may still hold trained state during the reset cycle, so gate explicitly
  assign pred_taken = MODE != BP_STATIC && !rst && btb_hit && pht_q[pred_pht_idx][1];
  assign pred_target = {btb_q[if_idx].target, 2'b00};
  assign upd = id_valid && !id_stall && !id_flush;
  assign mispredict = id_valid && !id_flush && (id_taken != id_pred_taken || (id_taken && id_target != id_pred_target));
  assign redirect_pc = id_taken ? id_target : id_pc + 32'd8;
  assign btb_we = upd && (!id_is_cond || id_taken);
  assign pht_we = upd && (!id_is_cond || id_taken || id_hit);
  assign br_count = br_count_q;
  assign mispred_count = mispred_count_q;
  sat_counter2 u_cnt (
    .cnt    (pht_q[id_pht_idx]),
    .inc    (id_is_cond && id_taken && id_hit),
    .dec    (id_is_cond && !id_taken && id_hit),
    .set    (!id_is_cond || (id_taken && !id_hit)),
    .set_val(id_is_cond ? CNT_WT : CNT_ST),
    .nxt    (pht_nxt)
  );
  always_comb begin
    btb_d = btb_q;
    pht_d = pht_q;
    if (btb_we) btb_d[id_idx] = '{valid: 1'b1, tag: TAG_MAX'(id_tag), target: id_target[31:2]};
    if (pht_we) pht_d[id_pht_idx] = pht_nxt;
    ghr_d = (MODE == BP_GSHARE && upd && id_is_cond) ? {ghr_q[IDX_W-2:0], id_taken} : ghr_q;
    br_count_d = upd ? br_count_q + 32'd1 : br_count_q;
    mispred_count_d = (upd && mispredict) ? mispred_count_q + 32'd1 : mispred_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_q <= '{default: '0};
      pht_q <= '{default: CNT_WNT};
      ghr_q <= '0;
      br_count_q <= '0;
      mispred_count_q <= '0;
    end else begin
      btb_q <= btb_d;
      pht_q <= pht_d;
      ghr_q <= ghr_d;
      br_count_q <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end
endmodule
